ibpl_out: RTL and testbench

IBPL_OUT -- requirements
Module: ibpl_out

---
 rtl/ibpl_pkg.sv | 15 +
 rtl/ibpl_out_chan.sv | 104 ++++++++++
 rtl/ibpl_out.sv | 97 +++++++++
 tb/tb_ibpl_out.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ibpl_pkg.sv
// Shared definitions for the IBPL output block: channel count, the
// short-detect threshold and the per-channel state encoding.
package ibpl_pkg;

  localparam int NUM_CHAN     = 6;
  localparam int SHORT_THRESH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } chan_state_t;

endpackage

// File: rtl/ibpl_out_chan.sv
// One IBPL output channel: direction/drive sequencing with a dead-time
// turnaround on both edges of the enable, plus a short detector that
// compares the synchronised pin readback against the level being driven.
module ibpl_out_chan
  import ibpl_pkg::*;
#(
  parameter bit INVERT      = 1'b0,
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic data,
  input  logic readback,
  output logic pin_out,
  output logic pin_dir,
  output logic short_det
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);
  localparam int SHORT_W = $clog2(SHORT_THRESH + 1);
  localparam logic [SHORT_W-1:0] SHORT_MAX = SHORT_W'(SHORT_THRESH);

  chan_state_t state, next_state;
  logic [7:0] cnt, next_cnt;
  logic next_out, next_dir;
  logic [SHORT_W-1:0] short_cnt;
  logic mismatch;

  // State, dead-time counter and registered pin levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pin_out <= INVERT;
      pin_dir <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      pin_out <= next_out;
      pin_dir <= next_dir;
    end
  end

  // Next state; a dropped enable wins over an expiring counter, and the
  // pin levels are computed from the next state so they track it without lag.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          next_state = ARM;
          next_cnt   = DEAD_LOAD;
        end
      end
      ARM: begin
        if (!enable) begin
          next_state = RELEASE;
          next_cnt   = DEAD_LOAD;
        end else if (cnt == 8'd0) begin
          next_state = DRIVE;
        end else begin
          next_cnt = cnt - 8'd1;
        end
      end
      DRIVE: begin
        if (!enable) begin
          next_state = RELEASE;
          next_cnt   = DEAD_LOAD;
        end
      end
      RELEASE: begin
        if (cnt == 8'd0) begin
          next_state = IDLE;
        end else begin
          next_cnt = cnt - 8'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
    next_dir = (next_state != IDLE);
    next_out = (next_state == DRIVE) ? (data ^ INVERT) : INVERT;
  end

  assign mismatch = (state == DRIVE) && (readback != pin_out);

  // Consecutive-mismatch counter, saturating at the detection threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      short_cnt <= '0;
    end else if (!mismatch) begin
      short_cnt <= '0;
    end else if (short_cnt != SHORT_MAX) begin
      short_cnt <= short_cnt + 1'b1;
    end
  end

  assign short_det = (short_cnt == SHORT_MAX);

endmodule

// File: rtl/ibpl_out.sv
// IBPL output block top: six sequenced output channels, readback
// synchroniser, activity LED stretchers and the plugin error flag.
module ibpl_out
  import ibpl_pkg::*;
#(
  parameter bit invert_signals = 1'b0,
  parameter int DEAD_CYCLES    = 4,
  parameter int LED_HOLD       = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] internal_out,
  input  logic [7:0] output_enable,
  input  logic [7:0] input_enable,
  input  logic [7:0] output_act,
  input  logic [5:0] diob_in,
  output logic [5:0] diob_out,
  output logic [5:0] diob_dir,
  output logic [7:0] internal_in,
  output logic [7:0] diob_led1,
  output logic [7:0] diob_led2,
  output logic       plugin_error
);

  localparam int LED_W = $clog2(LED_HOLD + 1);
  localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_HOLD);

  logic [5:0] sync1, sync2;
  logic [5:0] short_det;
  logic [5:0] led_on;
  logic [5:0] led2_q;
  logic       cfg_err;
  logic       unused_hi;

  assign unused_hi = ^{internal_out[7:6], output_enable[7:6],
                       input_enable[7:6], output_act[7:6]};

  // Two-flop synchroniser on the pin readback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= diob_in;
      sync2 <= sync1;
    end
  end

  assign internal_in = {2'b00, sync2 & input_enable[5:0]};

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    logic [LED_W-1:0] led_cnt;

    ibpl_out_chan #(
      .INVERT      (invert_signals),
      .DEAD_CYCLES (DEAD_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .enable    (output_enable[i]),
      .data      (internal_out[i]),
      .readback  (sync2[i]),
      .pin_out   (diob_out[i]),
      .pin_dir   (diob_dir[i]),
      .short_det (short_det[i])
    );

    // Activity stretcher: each strobe reloads, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        led_cnt <= '0;
      end else if (output_act[i]) begin
        led_cnt <= LED_LOAD;
      end else if (led_cnt != '0) begin
        led_cnt <= led_cnt - 1'b1;
      end
    end

    assign led_on[i] = (led_cnt != '0);
  end

  assign diob_led1 = {2'b00, led_on};
  assign diob_led2 = {2'b00, led2_q};
  assign cfg_err   = |(input_enable[5:0] & ~output_enable[5:0]);

  // Registered enable mirror and combined configuration/short error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led2_q       <= '0;
      plugin_error <= 1'b0;
    end else begin
      led2_q       <= output_enable[5:0];
      plugin_error <= cfg_err | (|short_det);
    end
  end

endmodule

// File: tb/tb_ibpl_out.sv
// Directed testbench for ibpl_out: a plain instance with a short LED hold
// and an inverted instance sharing the same stimulus.
module tb_ibpl_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] internal_out = '0;
  logic [7:0] output_enable = '0;
  logic [7:0] input_enable = '0;
  logic [7:0] output_act = '0;
  logic       short_mode = 1'b0;

  logic [5:0] diob_in_a, diob_out_a, diob_dir_a;
  logic [7:0] internal_in_a, diob_led1_a, diob_led2_a;
  logic       plugin_error_a;

  logic [5:0] diob_in_b, diob_out_b, diob_dir_b;
  logic [7:0] internal_in_b, diob_led1_b, diob_led2_b;
  logic       plugin_error_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Pins loop back to their readback; short_mode fakes a fight on channel 0.
  assign diob_in_a = diob_out_a ^ (short_mode ? 6'h01 : 6'h00);
  assign diob_in_b = diob_out_b;

  ibpl_out #(.invert_signals(1'b0), .DEAD_CYCLES(4), .LED_HOLD(10)) u_dut (
    .clk(clk), .rst(rst), .internal_out(internal_out),
    .output_enable(output_enable), .input_enable(input_enable),
    .output_act(output_act), .diob_in(diob_in_a), .diob_out(diob_out_a),
    .diob_dir(diob_dir_a), .internal_in(internal_in_a),
    .diob_led1(diob_led1_a), .diob_led2(diob_led2_a),
    .plugin_error(plugin_error_a)
  );

  ibpl_out #(.invert_signals(1'b1), .DEAD_CYCLES(4), .LED_HOLD(10)) u_inv (
    .clk(clk), .rst(rst), .internal_out(internal_out),
    .output_enable(output_enable), .input_enable(input_enable),
    .output_act(output_act), .diob_in(diob_in_b), .diob_out(diob_out_b),
    .diob_dir(diob_dir_b), .internal_in(internal_in_b),
    .diob_led1(diob_led1_b), .diob_led2(diob_led2_b),
    .plugin_error(plugin_error_b)
  );

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle on the following falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset values
    #12;
    checkOutput("rst_dir", {2'b0, diob_dir_a}, 8'h00);
    checkOutput("rst_out", {2'b0, diob_out_a}, 8'h00);
    checkOutput("rst_out_inv", {2'b0, diob_out_b}, 8'h3F);
    checkOutput("rst_led1", diob_led1_a, 8'h00);
    checkOutput("rst_led2", diob_led2_a, 8'h00);
    checkOutput("rst_in", internal_in_a, 8'h00);
    checkOutput("rst_err", {7'b0, plugin_error_a}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2);

    // Channel 0 turn-on sequence
    output_enable = 8'h01;
    internal_out  = 8'h01;
    applyStimulus(1);
    checkOutput("arm_dir_c1", {2'b0, diob_dir_a}, 8'h01);
    checkOutput("arm_out_c1", {2'b0, diob_out_a}, 8'h00);
    checkOutput("led2_c1", diob_led2_a, 8'h01);
    applyStimulus(3);
    checkOutput("arm_out_c4", {2'b0, diob_out_a}, 8'h00);
    checkOutput("arm_out_inv_c4", {2'b0, diob_out_b}, 8'h3F);
    applyStimulus(1);
    checkOutput("drive_out_c5", {2'b0, diob_out_a}, 8'h01);
    checkOutput("drive_dir_c5", {2'b0, diob_dir_a}, 8'h01);
    checkOutput("drive_out_inv_c5", {2'b0, diob_out_b}, 8'h3E);

    // Data follows with one cycle of latency; readback via synchroniser
    internal_out = 8'h00;
    applyStimulus(1);
    checkOutput("data_low", {2'b0, diob_out_a}, 8'h00);
    internal_out = 8'hC1;
    input_enable = 8'h01;
    applyStimulus(1);
    checkOutput("data_high", {2'b0, diob_out_a}, 8'h01);
    applyStimulus(2);
    checkOutput("readback", internal_in_a, 8'h01);
    checkOutput("no_err_drive", {7'b0, plugin_error_a}, 8'h00);

    // Turn-off: data released at once, direction after the dead time
    output_enable = 8'h00;
    input_enable  = 8'h00;
    applyStimulus(1);
    checkOutput("rel_out", {2'b0, diob_out_a}, 8'h00);
    checkOutput("rel_dir", {2'b0, diob_dir_a}, 8'h01);
    checkOutput("rel_out_inv", {2'b0, diob_out_b}, 8'h3F);
    applyStimulus(3);
    checkOutput("rel_dir_c4", {2'b0, diob_dir_a}, 8'h01);
    applyStimulus(1);
    checkOutput("rel_dir_off", {2'b0, diob_dir_a}, 8'h00);
    applyStimulus(2);

    // Channel 2 enable glitch 1->0->1
    internal_out  = 8'h04;
    output_enable = 8'h04;
    applyStimulus(1);
    checkOutput("glitch_arm_dir", {2'b0, diob_dir_a}, 8'h04);
    output_enable = 8'h00;
    applyStimulus(1);
    output_enable = 8'h04;
    checkOutput("glitch_out_2", {2'b0, diob_out_a}, 8'h00);
    for (int k = 3; k <= 10; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("glitch_out_%0d", k), {2'b0, diob_out_a}, 8'h00);
      if (k == 6) checkOutput("glitch_idle_dir", {2'b0, diob_dir_a}, 8'h00);
      if (k == 7) checkOutput("glitch_rearm_dir", {2'b0, diob_dir_a}, 8'h04);
    end
    applyStimulus(1);
    checkOutput("glitch_drive", {2'b0, diob_out_a}, 8'h04);
    output_enable = 8'h00;
    applyStimulus(6);

    // Readback enabled on a channel that is not an output
    input_enable = 8'h04;
    applyStimulus(1);
    checkOutput("cfg_err_set", {7'b0, plugin_error_a}, 8'h01);
    output_enable = 8'h04;
    applyStimulus(1);
    checkOutput("cfg_err_clr", {7'b0, plugin_error_a}, 8'h00);
    output_enable = 8'h00;
    input_enable  = 8'h00;
    applyStimulus(6);

    // Short detection on channel 0
    output_enable = 8'h01;
    internal_out  = 8'h01;
    applyStimulus(7);
    short_mode = 1'b1;
    applyStimulus(7);
    checkOutput("short_early", {7'b0, plugin_error_a}, 8'h00);
    applyStimulus(7);
    checkOutput("short_set", {7'b0, plugin_error_a}, 8'h01);
    checkOutput("short_inv_clean", {7'b0, plugin_error_b}, 8'h00);
    short_mode = 1'b0;
    applyStimulus(6);
    checkOutput("short_clr", {7'b0, plugin_error_a}, 8'h00);
    output_enable = 8'h00;
    applyStimulus(6);

    // LED stretch with retrigger on channel 3
    output_act = 8'h08;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1);
      output_act = (k == 5) ? 8'h08 : 8'h00;
      checkOutput($sformatf("led_t%0d", k), diob_led1_a,
                  (k <= 15) ? 8'h08 : 8'h00);
    end

    // Asynchronous reset while all channels drive (inverted instance)
    output_enable = 8'h3F;
    internal_out  = 8'h3F;
    applyStimulus(6);
    checkOutput("all_drive_inv", {2'b0, diob_out_b}, 8'h00);
    checkOutput("all_dir_inv", {2'b0, diob_dir_b}, 8'h3F);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_dir_inv", {2'b0, diob_dir_b}, 8'h00);
    checkOutput("arst_out_inv", {2'b0, diob_out_b}, 8'h3F);
    checkOutput("arst_out", {2'b0, diob_out_a}, 8'h00);
    checkOutput("arst_led2", diob_led2_b, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
